// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and divisor legality check for clk_div_prog
package clk_div_pkg;

    localparam int CLK_DIV_WIDTH_DEF = 8;
    localparam int CLK_DIV_MIN       = 2;
    localparam int CLK_DIV_DEFAULT   = 55;

    function automatic logic div_legal(input logic [31:0] d);
        return d >= 32'(CLK_DIV_MIN);
    endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// rtl/clk_div_prog_if.sv - divisor request handshake between a programming master and clk_div_prog
interface clk_div_prog_if import clk_div_pkg::*; #(
    parameter int WIDTH = CLK_DIV_WIDTH_DEF
);

    logic [WIDTH-1:0] div_in;
    logic             div_valid;
    logic             div_ready;
    logic             div_err;

    modport master (
        output div_in,
        output div_valid,
        input  div_ready,
        input  div_err
    );

    modport slave (
        input  div_in,
        input  div_valid,
        output div_ready,
        output div_err
    );

endinterface

// File: rtl/clk_div_half_ext.sv
// rtl/clk_div_half_ext.sv - falling-edge half-cycle extender, present only with CLK_DIV_ODD50_EN
`ifdef CLK_DIV_ODD50_EN
module clk_div_half_ext (
    input  logic clk,
    input  logic rst,
    input  logic out_p,
    input  logic odd,
    output logic clk_out
);

    logic out_n;

    // Half a cycle behind out_p; OR-ing it in stretches the high phase by half a clk for odd D.
    always_ff @(negedge clk) begin
        if (rst) begin
            out_n <= 1'b0;
        end else begin
            out_n <= out_p;
        end
    end

    assign clk_out = out_p | (out_n & odd);

endmodule
`endif

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable clock divider; CLK_DIV_ODD50_EN adds 50% duty for odd D
module clk_div_prog import clk_div_pkg::*; #(
    parameter int WIDTH       = CLK_DIV_WIDTH_DEF,
    parameter int DIV_DEFAULT = CLK_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    clk_div_prog_if.slave    div_bus,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] cnt_o,
    output logic [WIDTH-1:0] div_cur
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] d_cur;
    logic [WIDTH-1:0] d_pend;
    logic             pend_v;
    logic             out_p;
    logic             tick_r;
    logic             err_r;

    logic at_end;
    logic xfer;
    logic legal;
    logic apply;

    assign at_end = (cnt == d_cur - WIDTH'(1));
    assign xfer   = div_bus.div_valid && !pend_v;
    assign legal  = div_legal(32'(div_bus.div_in));
    // Loads land only on a period boundary, or at once while stopped, so clk_out never runts.
    assign apply  = pend_v && (!en || at_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            d_cur  <= WIDTH'(DIV_DEFAULT);
            d_pend <= WIDTH'(DIV_DEFAULT);
            pend_v <= 1'b0;
            out_p  <= 1'b0;
            tick_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            err_r <= xfer && !legal;

            if (apply) begin
                d_cur  <= d_pend;
                pend_v <= 1'b0;
            end else if (xfer && legal) begin
                d_pend <= div_bus.div_in;
                pend_v <= 1'b1;
            end

            if (!en) begin
                cnt    <= '0;
                out_p  <= 1'b0;
                tick_r <= 1'b0;
            end else begin
                cnt    <= at_end ? '0 : cnt + WIDTH'(1);
                out_p  <= (cnt < (d_cur >> 1));
                tick_r <= (cnt == '0);
            end
        end
    end

    assign div_bus.div_ready = !pend_v;
    assign div_bus.div_err   = err_r;
    assign tick              = tick_r;
    assign cnt_o             = cnt;
    assign div_cur           = d_cur;

`ifdef CLK_DIV_ODD50_EN
    clk_div_half_ext u_half_ext (
        .clk     (clk),
        .rst     (rst),
        .out_p   (out_p),
        .odd     (d_cur[0]),
        .clk_out (clk_out)
    );
`else
    assign clk_out = out_p;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - directed and randomized checks of clk_div_prog against a period-position model
module tb_clk_div_prog;
    import clk_div_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clk_out;
    logic       tick;
    logic [7:0] cnt_o;
    logic [7:0] div_cur;

    clk_div_prog_if #(.WIDTH(8)) bus ();

    clk_div_prog #(.WIDTH(8), .DIV_DEFAULT(55)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_bus (bus),
        .clk_out (clk_out),
        .tick    (tick),
        .cnt_o   (cnt_o),
        .div_cur (div_cur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: position within the current period plus the divisor governing it.
    int m_pos;
    int m_d;
    int m_pend;
    bit m_pend_v;
    bit m_high;
    bit m_tick;
    bit m_err;
    bit m_high_n;

    function automatic int exp_hi(input int d);
`ifdef CLK_DIV_ODD50_EN
        return (d + 1) / 2;
`else
        return d / 2;
`endif
    endfunction

    task automatic model_edge();
        bit take;
        take = bus.div_valid && !m_pend_v;
        if (rst) begin
            m_pos = 0; m_d = 55; m_pend_v = 0;
            m_high = 0; m_tick = 0; m_err = 0;
            return;
        end
        m_err = take && (bus.div_in < 2);
        if (!en) begin
            m_pos = 0; m_high = 0; m_tick = 0;
            if (m_pend_v) begin m_d = m_pend; m_pend_v = 0; end
        end else begin
            m_tick = (m_pos == 0);
            m_high = (m_pos < m_d / 2);
            m_pos  = m_pos + 1;
            if (m_pos == m_d) begin
                m_pos = 0;
                if (m_pend_v) begin m_d = m_pend; m_pend_v = 0; end
            end
        end
        if (take && bus.div_in >= 2) begin
            m_pend = int'(bus.div_in); m_pend_v = 1;
        end
    endtask

    always @(negedge clk) m_high_n = rst ? 1'b0 : m_high;

    task automatic step();
        bit exp_clk;
        @(posedge clk);
        model_edge();
        #1;
`ifdef CLK_DIV_ODD50_EN
        exp_clk = m_high | (m_high_n & (m_d % 2 == 1));
`else
        exp_clk = m_high;
`endif
        if (chk_on) begin
            check("m_cnt",     32'(cnt_o),         32'(m_pos));
            check("m_tick",    32'(tick),          32'(m_tick));
            check("m_clk_out", 32'(clk_out),       32'(exp_clk));
            check("m_ready",   32'(bus.div_ready), 32'(!m_pend_v));
            check("m_err",     32'(bus.div_err),   32'(m_err));
            check("m_div_cur", 32'(div_cur),       32'(m_d));
        end
    endtask

    task automatic request(input int d);
        bus.div_valid = 1'b1;
        bus.div_in    = 8'(d);
        step();
        bus.div_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int v, input string tag);
        int n = 0;
        while (cnt_o != 8'(v) && n < 300) begin step(); n++; end
        check(tag, 32'(cnt_o == 8'(v)), 32'd1);
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        while (!tick && n < 600) begin step(); n++; end
        check(tag, 32'(tick), 32'd1);
    endtask

    // Called on a tick sample: counts cycles to the next tick and high samples in between.
    task automatic measure(input int d, input string tag);
        int per = 0;
        int hi  = int'(clk_out);
        while (per < 600) begin
            step(); per++;
            if (tick) break;
            hi += int'(clk_out);
        end
        check({tag, "_period"}, 32'(per), 32'(d));
        check({tag, "_high"},   32'(hi),  32'(exp_hi(d)));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; bus.div_valid = 1'b0; bus.div_in = '0;
        step(); step();
        chk_on = 1;
        step();
        check("rst_div_cur", 32'(div_cur),       32'd55);
        check("rst_ready",   32'(bus.div_ready), 32'd1);
        check("rst_clk_out", 32'(clk_out),       32'd0);
        check("rst_cnt",     32'(cnt_o),         32'd0);

        rst = 1'b0; en = 1'b1;
        step();
        check("first_tick", 32'(tick),    32'd1);
        check("first_rise", 32'(clk_out), 32'd1);
        measure(55, "d55");

        request(1);
        check("err_pulse", 32'(bus.div_err),   32'd1);
        check("err_ready", 32'(bus.div_ready), 32'd1);
        step();
        check("err_clear", 32'(bus.div_err), 32'd0);
        check("err_d_cur", 32'(div_cur),     32'd55);

        wait_cnt(10, "wait_cnt10");
        en = 1'b0;
        step(); step();
        check("en_off_clk", 32'(clk_out), 32'd0);
        check("en_off_cnt", 32'(cnt_o),   32'd0);
        en = 1'b1;
        step();
        check("restart_tick", 32'(tick), 32'd1);

        wait_cnt(25, "wait_cnt25");
        request(6);
        check("pend6_ready", 32'(bus.div_ready), 32'd0);
        wait_cnt(30, "wait_cnt30");
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_drop_ready", 32'(bus.div_ready), 32'd1);
        check("rst_drop_d_cur", 32'(div_cur),       32'd55);
        check("rst_drop_cnt",   32'(cnt_o),         32'd0);
        step();
        check("rst_restart_tick", 32'(tick), 32'd1);
        measure(55, "d55_after_rst");

        wait_cnt(20, "wait_cnt20");
        request(4);
        check("load4_ready", 32'(bus.div_ready), 32'd0);
        wait_tick("tick_d4");
        check("d4_cur",   32'(div_cur),       32'd4);
        check("d4_ready", 32'(bus.div_ready), 32'd1);
        measure(4, "d4");

        request(7);
        check("load7_ready", 32'(bus.div_ready), 32'd0);
        request(9);
        wait_tick("tick_d7");
        check("d7_cur", 32'(div_cur), 32'd7);
        measure(7, "d7");
        request(9);
        wait_tick("tick_d9");
        check("d9_cur", 32'(div_cur), 32'd9);
        measure(9, "d9");

        for (int i = 0; i < 1500; i++) begin
            bus.div_valid = ($urandom_range(0, 7) == 0);
            bus.div_in    = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255))
                                                         : 8'($urandom_range(0, 20));
            en  = ($urandom_range(0, 31) != 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; bus.div_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
